// File: rtl/flow_lights_decoder_if.sv
// LED bus between a flow-light generator and its checker.
// The generator drives the pattern and the checker reports lock, code, direction and period.
interface flow_lights_decoder_if #(
    parameter int unsigned CNT_W = 24
);
    logic [7:0]       led;
    logic             locked;
    logic [1:0]       freq_code;
    logic             dir;
    logic [CNT_W-1:0] period_meas;
    logic             step_pulse;
    logic             err;

    modport master (
        output led,
        input  locked, freq_code, dir, period_meas, step_pulse, err
    );

    modport slave (
        input  led,
        output locked, freq_code, dir, period_meas, step_pulse, err
    );
endinterface

// File: rtl/flow_lights_decoder.sv
// Receive-side checker for the 8-bit running-light bus: validates one-hot rotation,
// measures the step period and decodes the generator's frequency code.
module flow_lights_decoder #(
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned P0     = 2_500_000,
    parameter int unsigned P1     = 5_000_000,
    parameter int unsigned P2     = 10_000_000,
    parameter int unsigned P3     = 20_000_000,
    parameter int unsigned TOL    = 4,
    parameter int unsigned LOCK_N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    flow_lights_decoder_if.slave bus
);
    localparam int unsigned STALL = P3 + TOL + 1;
    localparam int unsigned MC_W  = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {IDLE, SYNC, DIR, TRACK} state_t;

    state_t           state;
    logic [7:0]       led_q;
    logic [7:0]       led_prev;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  match_cnt;
    logic [1:0]       run_code;

    logic       step;
    logic       one_hot;
    logic       is_l;
    logic       is_r;
    logic       stall;
    logic       cls_ok;
    logic [1:0] cls_code;

    function automatic logic near(input logic [31:0] v, input logic [31:0] p);
        return ((v + TOL) >= p) && (v <= (p + TOL));
    endfunction

    always_comb begin
        step     = (led_q != led_prev);
        one_hot  = (led_q != '0) && ((led_q & (led_q - 8'd1)) == '0);
        is_l     = one_hot && (led_q == {led_prev[6:0], led_prev[7]});
        is_r     = one_hot && (led_q == {led_prev[0], led_prev[7:1]});
        stall    = (32'(cnt) >= STALL);
        cls_ok   = 1'b1;
        cls_code = 2'd0;
        if (near(32'(cnt), P0))      cls_code = 2'd0;
        else if (near(32'(cnt), P1)) cls_code = 2'd1;
        else if (near(32'(cnt), P2)) cls_code = 2'd2;
        else if (near(32'(cnt), P3)) cls_code = 2'd3;
        else                         cls_ok   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            led_q           <= '0;
            led_prev        <= '0;
            cnt             <= '0;
            match_cnt       <= '0;
            run_code        <= '0;
            bus.locked      <= 1'b0;
            bus.freq_code   <= '0;
            bus.dir         <= 1'b0;
            bus.period_meas <= '0;
            bus.step_pulse  <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            led_q          <= bus.led;
            led_prev       <= led_q;
            bus.step_pulse <= 1'b0;
            bus.err        <= 1'b0;

            if (step)            cnt <= CNT_W'(1);
            else if (cnt != '1)  cnt <= cnt + 1'b1;
            if (step)            bus.period_meas <= cnt;

            if (step && led_q == '0) begin
                state      <= IDLE;
                bus.locked <= 1'b0;
                match_cnt  <= '0;
            end else if (step && !one_hot) begin
                state      <= IDLE;
                bus.err    <= 1'b1;
                bus.locked <= 1'b0;
                match_cnt  <= '0;
            end else if (step) begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (is_l || is_r) begin
                            state          <= DIR;
                            bus.dir        <= is_r;
                            bus.step_pulse <= 1'b1;
                            match_cnt      <= '0;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                    default: begin
                        // Jump, reversal and unclassifiable period all resync on the new pattern.
                        if (!(is_l || is_r) || (is_r != bus.dir) || !cls_ok) begin
                            state      <= SYNC;
                            bus.err    <= 1'b1;
                            bus.locked <= 1'b0;
                            match_cnt  <= '0;
                        end else begin
                            bus.step_pulse <= 1'b1;
                            run_code       <= cls_code;
                            if (match_cnt != '0 && cls_code != run_code) begin
                                state      <= DIR;
                                bus.locked <= 1'b0;
                                match_cnt  <= MC_W'(1);
                            end else begin
                                if (32'(match_cnt) < LOCK_N) match_cnt <= match_cnt + 1'b1;
                                if (32'(match_cnt) + 1 >= LOCK_N) begin
                                    state         <= TRACK;
                                    bus.locked    <= 1'b1;
                                    bus.freq_code <= cls_code;
                                end
                            end
                        end
                    end
                endcase
            end else if ((state == DIR || state == TRACK) && stall) begin
                state      <= SYNC;
                bus.err    <= 1'b1;
                bus.locked <= 1'b0;
                match_cnt  <= '0;
                cnt        <= CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_flow_lights_decoder.sv
// Directed bench for flow_lights_decoder with short step periods.
module tb_flow_lights_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] cur = 8'h00;

    int unsigned tests  = 0;
    int unsigned failed = 0;
    int unsigned cyc = 0;
    int unsigned step_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned last_step_cyc = 0;
    int unsigned last_err_cyc = 0;
    int unsigned s0;
    int unsigned e0;

    flow_lights_decoder_if #(.CNT_W(16)) bus ();

    flow_lights_decoder #(
        .CNT_W(16), .P0(16), .P1(32), .P2(64), .P3(128), .TOL(2), .LOCK_N(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.step_pulse === 1'b1) begin
            step_cnt      = step_cnt + 1;
            last_step_cyc = cyc;
        end
        if (bus.err === 1'b1) begin
            err_cnt      = err_cnt + 1;
            last_err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] p, input int n);
        bus.led = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic steps(input int n, input bit right, input int per);
        for (int i = 0; i < n; i++) begin
            cur = right ? {cur[0], cur[7:1]} : {cur[6:0], cur[7]};
            drive(cur, per);
        end
    endtask

    initial begin
        bus.led = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_locked", bus.locked, 0);
        check("rst_code", bus.freq_code, 0);
        check("rst_period", bus.period_meas, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Left rotation at P1, lock after 1 + 3 steps, then wrap.
        s0 = step_cnt; e0 = err_cnt;
        cur = 8'h01; drive(cur, 32);
        steps(1, 0, 32);
        check("sync_unlocked", bus.locked, 0);
        steps(3, 0, 32);
        check("p1_locked", bus.locked, 1);
        check("p1_code", bus.freq_code, 1);
        check("p1_dir", bus.dir, 0);
        check("p1_period", bus.period_meas, 32);
        check("p1_steps", step_cnt - s0, 4);
        steps(4, 0, 32);
        check("wrap_cur", cur, 8'h01);
        check("wrap_locked", bus.locked, 1);
        check("wrap_steps", step_cnt - s0, 8);
        check("p1_no_err", err_cnt - e0, 0);

        // Reversal error, relock right at P1, then move to P0.
        e0 = err_cnt;
        steps(1, 1, 32);
        check("rev_err", err_cnt - e0, 1);
        check("rev_unlocked", bus.locked, 0);
        steps(4, 1, 32);
        check("right_locked", bus.locked, 1);
        check("right_dir", bus.dir, 1);
        e0 = err_cnt;
        steps(1, 1, 16);
        check("p1_tail_locked", bus.locked, 1);
        steps(1, 1, 16);
        check("chg_unlocked", bus.locked, 0);
        check("chg_code_hold", bus.freq_code, 1);
        check("chg_period", bus.period_meas, 16);
        steps(2, 1, 16);
        check("p0_locked", bus.locked, 1);
        check("p0_code", bus.freq_code, 0);
        check("chg_no_err", err_cnt - e0, 0);

        // Lock at P2, then a non-one-hot pattern and a return to zero.
        steps(1, 1, 64);
        steps(3, 1, 64);
        check("p2_locked", bus.locked, 1);
        check("p2_code", bus.freq_code, 2);
        e0 = err_cnt;
        bus.led = 8'h05;
        @(negedge clk);
        check("bad_err_early", bus.err, 0);
        @(negedge clk);
        check("bad_err_pulse", bus.err, 1);
        check("bad_unlocked", bus.locked, 0);
        @(negedge clk);
        check("bad_err_one", bus.err, 0);
        cur = 8'h00; drive(cur, 4);
        check("zero_no_err", err_cnt - e0, 1);
        check("zero_unlocked", bus.locked, 0);

        // Non-adjacent jump 02 -> 08, then relock.
        cur = 8'h01; drive(cur, 32);
        steps(9, 0, 32);
        check("pre_jump_cur", cur, 8'h02);
        check("pre_jump_locked", bus.locked, 1);
        e0 = err_cnt;
        cur = 8'h08; drive(cur, 32);
        check("jump_err", err_cnt - e0, 1);
        check("jump_unlocked", bus.locked, 0);
        steps(1, 0, 32);
        check("jump_sync", bus.locked, 0);
        steps(3, 0, 32);
        check("jump_relock", bus.locked, 1);
        check("jump_code", bus.freq_code, 1);

        // Lock at P3, stall, then an unclassifiable period of 50.
        steps(1, 0, 128);
        steps(3, 0, 128);
        check("p3_locked", bus.locked, 1);
        check("p3_code", bus.freq_code, 3);
        e0 = err_cnt;
        for (int i = 0; i < 400 && err_cnt == e0; i++) @(negedge clk);
        check("stall_err", err_cnt - e0, 1);
        check("stall_delay", last_err_cyc - last_step_cyc, 131);
        check("stall_unlocked", bus.locked, 0);
        steps(1, 0, 50);
        e0 = err_cnt;
        steps(1, 0, 50);
        check("p50_err", err_cnt - e0, 1);
        check("p50_period", bus.period_meas, 50);
        check("p50_unlocked", bus.locked, 0);

        // Async reset between edges, then relock.
        steps(1, 0, 32);
        steps(3, 0, 32);
        check("pre_rst_locked", bus.locked, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_code", bus.freq_code, 0);
        check("arst_dir", bus.dir, 0);
        check("arst_period", bus.period_meas, 0);
        check("arst_step", bus.step_pulse, 0);
        check("arst_err", bus.err, 0);
        @(negedge clk);
        cur = 8'h00; bus.led = cur;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        e0 = err_cnt;
        cur = 8'h01; drive(cur, 32);
        steps(4, 0, 32);
        check("relock_locked", bus.locked, 1);
        check("relock_code", bus.freq_code, 1);
        check("relock_dir", bus.dir, 0);
        check("relock_period", bus.period_meas, 32);
        check("relock_no_err", err_cnt - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
